fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//   Round-robin arbiter that shares the single write port of a FIFO between NUM_REQ requesters
//   (e.g. CPU MMIO path, debug/loader path) using per-requester valid/ready handshakes.
//   Sits directly in front of the FIFO: drives its write data and write enable, observes its full flag.
//   Guarantees fairness (no starvation) and never issues a write while the FIFO reports full.
// PARAMETERS
//   DATA_WIDTH  8  width of one FIFO word
//   NUM_REQ     2  number of requesters, legal range 2..8
// PORTS
//   i_CLK            in   1                     clock, all state on rising edge
//   i_RESET          in   1                     asynchronous, active-high reset
//   i_Req_Valid      in   NUM_REQ               bit k: requester k has a word to write
//   i_Req_Data       in   NUM_REQ*DATA_WIDTH    word of requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   i_Req_Last       in   NUM_REQ               bit k: current word of requester k ends its packet (lock feature)
//   o_Req_Ready      out  NUM_REQ               bit k: word of requester k is accepted this cycle
//   o_Grant          out  NUM_REQ               one-hot (or zero) current grant
//   i_Fifo_Full      in   1                     FIFO full flag
//   o_Fifo_Data      out  DATA_WIDTH            FIFO write data
//   o_Fifo_Write_EN  out  1                     FIFO write enable
//   o_Locked         out  1                     arbiter is holding a packet lock
// BEHAVIOUR
//   - Only sequential state: r_Last (index of last served requester, $clog2(NUM_REQ) bits) and lock
//     state (IDLE / LOCKED + r_Lock_Idx). Reset: r_Last = NUM_REQ-1, state IDLE, so requester 0 wins first.
//   - Outputs are combinational from state and inputs. Zero-latency: accept and write happen in the same cycle.
//   - Grant (IDLE): first valid requester scanning r_Last+1, r_Last+2, ... modulo NUM_REQ (wraps to 0).
//     No valid -> o_Grant = 0.
//   - Grant is computed regardless of i_Fifo_Full, so it holds steady while the FIFO is full.
//   - o_Req_Ready = o_Grant & {NUM_REQ{~i_Fifo_Full}}. o_Fifo_Write_EN = |(o_Req_Ready & i_Req_Valid).
//   - o_Fifo_Data = data of the granted requester. All zeros when o_Grant = 0.
//   - Transfer = o_Fifo_Write_EN. On a transfer r_Last <= granted index. Otherwise r_Last holds.
//   - Full: no write is issued, no ready is asserted, r_Last is unchanged. Requesters must hold valid and data.
//   - While i_RESET is high: o_Grant = 0, o_Req_Ready = 0, o_Fifo_Write_EN = 0, o_Fifo_Data = 0, o_Locked = 0.
//     Reset mid-packet clears the lock and restores r_Last = NUM_REQ-1.
// CONFIGURATION
//   Macro FIFO_ARB_LOCK_EN (packet lock).
//   Defined:
//     - A transfer with i_Req_Last[k] = 0 while IDLE -> state LOCKED, r_Lock_Idx = k.
//     - While LOCKED: o_Grant = one-hot(r_Lock_Idx) even if that requester's valid is 0.
//       No other requester is served.
//     - A transfer with last = 1 -> IDLE, and r_Last = r_Lock_Idx.
//     - o_Locked = (state == LOCKED).
//   Undefined:
//     - i_Req_Last is ignored; every transfer is a single-word packet.
//     - o_Locked is tied to 0. The port list is identical in both builds.
// TESTING
//   1. Assert i_RESET with valid=2'b11 -> grant=0, write_en=0. Release -> grant=2'b01, data=req0 word,
//      write_en=1.
//   2. NUM_REQ=2, valid=2'b11 held, full=0, data 0xA0/0xB0 -> grants 01,10,01,10 on consecutive cycles.
//      FIFO receives A0,B0,A0,B0.
//   3. valid=2'b01, full=1 for 3 cycles -> grant=01, ready=0, write_en=0 throughout.
//      Full drops -> write that cycle, then grant rotation resumes.
//   4. NUM_REQ=3, r_Last=2, valid=3'b110 -> grant 3'b010.
//      Next cycle with valid=3'b101 -> grant 3'b100 (wrap check).
//   5. LOCK_EN: req0 sends 3 words, last on 3rd, req1 valid throughout -> FIFO gets r0,r0,r0,r1.
//      o_Locked=1 for cycles 1-2. Without macro -> r0,r1,r0,r1.
//   6. LOCK_EN: reset pulsed after 1st of 3 locked words -> o_Locked=0. Next grant goes to requester 0
//      by round-robin with r_Last=NUM_REQ-1.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter in front of a FIFO write port.
// Optional packet lock: define FIFO_ARB_LOCK_EN.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2
) (
  input  logic                          i_CLK,
  input  logic                          i_RESET,
  input  logic [NUM_REQ-1:0]            i_Req_Valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]            i_Req_Last,
  output logic [NUM_REQ-1:0]            o_Req_Ready,
  output logic [NUM_REQ-1:0]            o_Grant,
  input  logic                          i_Fifo_Full,
  output logic [DATA_WIDTH-1:0]         o_Fifo_Data,
  output logic                          o_Fifo_Write_EN,
  output logic                          o_Locked
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] r_Last;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand;
  logic             rr_hit;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             locked;
  logic             transfer;

  // First valid requester after the last one served, wrapping
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(r_Last) + i) % NUM_REQ);
      if (!rr_hit && i_Req_Valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

`ifdef FIFO_ARB_LOCK_EN
  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t           r_State;
  state_t           w_State;
  logic [IDX_W-1:0] r_Lock_Idx;
  logic [IDX_W-1:0] w_Lock_Idx;

  assign locked  = (r_State == S_LOCKED);
  assign gnt_idx = locked ? r_Lock_Idx : rr_idx;
  assign gnt_vld = locked | rr_hit;

  // Lock state register
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_State    <= S_IDLE;
      r_Lock_Idx <= '0;
    end else begin
      r_State    <= w_State;
      r_Lock_Idx <= w_Lock_Idx;
    end
  end

  // A non-final word holds the port for its requester
  always_comb begin
    w_State    = r_State;
    w_Lock_Idx = r_Lock_Idx;
    if (transfer) begin
      if (!i_Req_Last[gnt_idx]) begin
        w_State    = S_LOCKED;
        w_Lock_Idx = gnt_idx;
      end else begin
        w_State    = S_IDLE;
      end
    end
  end
`else
  logic unused_last;

  assign unused_last = ^i_Req_Last;
  assign locked      = 1'b0;
  assign gnt_idx     = rr_idx;
  assign gnt_vld     = rr_hit;
`endif

  // Grant, handshake and FIFO write, all blanked during reset
  always_comb begin
    o_Grant         = '0;
    o_Req_Ready     = '0;
    o_Fifo_Data     = '0;
    o_Fifo_Write_EN = 1'b0;
    if (!i_RESET && gnt_vld) begin
      o_Grant[gnt_idx] = 1'b1;
      o_Req_Ready      = o_Grant & {NUM_REQ{~i_Fifo_Full}};
      o_Fifo_Write_EN  = |(o_Req_Ready & i_Req_Valid);
      o_Fifo_Data      =
        i_Req_Data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign transfer = o_Fifo_Write_EN;
  assign o_Locked = locked & ~i_RESET;

  // Remember who was served last
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET)
      r_Last <= LAST_RST;
    else if (transfer)
      r_Last <= gnt_idx;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: two instances (2 and 3
// requesters) against a behavioural reference model.
module tb_fifo_write_arbiter;

`ifdef FIFO_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  va, la, ra, ga;
  logic [15:0] da;
  logic        fa, wea, lka;
  logic [7:0]  fda;

  logic [2:0]  vb, lb, rb, gb;
  logic [23:0] db;
  logic        fb, web, lkb;
  logic [7:0]  fdb;

  fifo_write_arbiter #(.DATA_WIDTH(8), .NUM_REQ(2)) dut_a (
    .i_CLK(clk), .i_RESET(rst),
    .i_Req_Valid(va), .i_Req_Data(da), .i_Req_Last(la),
    .o_Req_Ready(ra), .o_Grant(ga), .i_Fifo_Full(fa),
    .o_Fifo_Data(fda), .o_Fifo_Write_EN(wea), .o_Locked(lka)
  );

  fifo_write_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3)) dut_b (
    .i_CLK(clk), .i_RESET(rst),
    .i_Req_Valid(vb), .i_Req_Data(db), .i_Req_Last(lb),
    .o_Req_Ready(rb), .o_Grant(gb), .i_Fifo_Full(fb),
    .o_Fifo_Data(fdb), .o_Fifo_Write_EN(web), .o_Locked(lkb)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model state: last served, lock flag, lock owner
  int m_last[2] = '{1, 2};
  bit m_lock[2] = '{1'b0, 1'b0};
  int m_lidx[2] = '{0, 0};
  int NR[2]     = '{2, 3};

  bit         obs_we_a;
  logic [7:0] obs_d_a;
  logic [7:0] wr_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_check(
    int u, string nm,
    logic [7:0] v, logic [63:0] d, logic [7:0] l, bit full,
    logic [7:0] g_o, logic [7:0] r_o, logic we_o,
    logic [7:0] d_o, logic lk_o);
    int         k;
    logic [7:0] eg, er, ed;
    bit         ewe, elk;
    k = -1;
    if (!rst) begin
      if (LOCK && m_lock[u]) k = m_lidx[u];
      else
        for (int i = 1; i <= NR[u]; i++) begin
          int c;
          c = (m_last[u] + i) % NR[u];
          if (k < 0 && v[c]) k = c;
        end
    end
    eg  = (k < 0) ? 8'h00 : 8'(1 << k);
    er  = full ? 8'h00 : eg;
    ewe = (k >= 0) && !full && v[k];
    ed  = (k < 0) ? 8'h00 : d[k*8 +: 8];
    elk = !rst && LOCK && m_lock[u];
    chk({nm, ".grant"}, 32'(g_o), 32'(eg));
    chk({nm, ".ready"}, 32'(r_o), 32'(er));
    chk({nm, ".wr_en"}, 32'(we_o), 32'(ewe));
    chk({nm, ".data"},  32'(d_o), 32'(ed));
    chk({nm, ".locked"}, 32'(lk_o), 32'(elk));
    if (rst) begin
      m_last[u] = NR[u] - 1;
      m_lock[u] = 1'b0;
    end else if (ewe) begin
      m_last[u] = k;
      if (LOCK) begin
        m_lock[u] = !l[k];
        if (!l[k]) m_lidx[u] = k;
      end
    end
  endtask

  // check both instances mid-cycle, then advance one clock
  task automatic step();
    #2;
    model_check(0, "A", {6'b0, va}, {48'b0, da}, {6'b0, la}, fa,
                {6'b0, ga}, {6'b0, ra}, wea, fda, lka);
    obs_we_a = wea;
    obs_d_a  = fda;
    model_check(1, "B", {5'b0, vb}, {40'b0, db}, {5'b0, lb}, fb,
                {5'b0, gb}, {5'b0, rb}, web, fdb, lkb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w0[3];
    logic [7:0] exp5[4];
    int p0;
    w0 = '{8'h11, 8'h22, 8'h33};
    if (LOCK) exp5 = '{8'h11, 8'h22, 8'h33, 8'hB0};
    else      exp5 = '{8'h11, 8'hB0, 8'h22, 8'hB0};

    // reset held with both requesters valid
    rst = 1'b1;
    va = 2'b11; da = 16'hB0A0; la = 2'b11; fa = 1'b0;
    vb = 3'b110; db = 24'hC0B0A0; lb = 3'b111; fb = 1'b0;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    #2;
    chk("t1_grant", 32'(ga), 32'h1);
    chk("t1_data", 32'(fda), 32'hA0);
    chk("t1_wren", 32'(wea), 32'h1);
    chk("t4_grant_b", 32'(gb), 32'h2);
    step();

    // alternation; B wraps from 1 to 2 over 0
    vb = 3'b101;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t2_grant", 32'(ga), (i % 2 == 0) ? 32'h2 : 32'h1);
      if (i == 0) chk("t4_wrap_b", 32'(gb), 32'h4);
      step();
      vb = 3'b000;
    end

    // full stalls requester 0, grant held
    va = 2'b01; fa = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t3_grant", 32'(ga), 32'h1);
      chk("t3_ready", 32'(ra), 32'h0);
      chk("t3_wren", 32'(wea), 32'h0);
      step();
    end
    fa = 1'b0;
    step();
    va = 2'b11;
    #2;
    chk("t3_resume", 32'(ga), 32'h2);
    step();

    // three-word packet from req0 against a busy req1
    rst = 1'b1;
    step();
    rst = 1'b0;
    p0 = 0;
    wr_q.delete();
    for (int i = 0; i < 4; i++) begin
      va = {1'b1, p0 < 3};
      da = {8'hB0, w0[p0 < 3 ? p0 : 2]};
      la = {1'b1, p0 == 2};
      step();
      if (obs_we_a) wr_q.push_back(obs_d_a);
      if (ra[0] === 1'b0) begin end
      if (obs_we_a && obs_d_a != 8'hB0) p0++;
    end
    chk("t5_count", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t5_word", (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF,
          32'(exp5[i]));

    // reset in the middle of a packet
    rst = 1'b1;
    step();
    rst = 1'b0;
    va = 2'b11; da = {8'hB0, 8'h11}; la = 2'b10;
    step();
    rst = 1'b1;
    #2;
    chk("t6_locked_rst", 32'(lka), 32'h0);
    step();
    rst = 1'b0;
    la = 2'b11;
    #2;
    chk("t6_grant", 32'(ga), 32'h1);
    chk("t6_locked", 32'(lka), 32'h0);
    step();

    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      va = 2'($urandom);
      da = 16'($urandom);
      la = 2'($urandom);
      fa = ($urandom_range(0, 3) == 0);
      vb = 3'($urandom);
      db = 24'($urandom);
      lb = 3'($urandom);
      fb = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
